uart_debug_controller: RTL

Command sequencer for the pipeline debug unit. Bytes arrive from the host through the UART receive FIFO. The block decodes them as single-byte commands and drives the datapath clock-enable and reset. It then streams a framed dump of pipeline/register state into the UART transmit FIFO. It sits between the UART wrapper (readFlag/receivedData/dataAvailable, writeFlag/dataToSend) and the datapath debug port.

---
 rtl/uart_debug_controller_if.sv | 25 ++
 rtl/uart_debug_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_debug_controller_if.sv
// Bundle of the UART FIFO handshake and datapath debug-port signals seen by the
// debug command sequencer; master is the sequencer, slave is the surrounding system.
interface uart_debug_controller_if;
    logic       dataAvailable;
    logic [7:0] receivedData;
    logic       readFlag;
    logic       writeFlag;
    logic [7:0] dataToSend;
    logic       halted;
    logic       pipe_enable;
    logic       pipe_reset;
    logic [7:0] debug_addr;
    logic [7:0] debug_data;
    logic       running;

    modport master (
        input  dataAvailable, receivedData, halted, debug_data,
        output readFlag, writeFlag, dataToSend, pipe_enable, pipe_reset, debug_addr, running
    );

    modport slave (
        output dataAvailable, receivedData, halted, debug_data,
        input  readFlag, writeFlag, dataToSend, pipe_enable, pipe_reset, debug_addr, running
    );
endinterface

// File: rtl/uart_debug_controller.sv
// Single-byte command sequencer for the pipeline debug unit: run/step/pause/reset the
// datapath and stream a 0xA5-headed dump of DUMP_BYTES debug registers into the UART TX FIFO.
module uart_debug_controller #(
    parameter int DUMP_BYTES = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    uart_debug_controller_if.master         bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DUMP = 2'd3
    } state_t;

    localparam logic [7:0] CMD_CONT  = 8'h63;
    localparam logic [7:0] CMD_STEP  = 8'h73;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [7:0] CMD_RESET = 8'h72;
    localparam logic [7:0] CMD_PAUSE = 8'h70;
    localparam logic [7:0] RSP_ACK   = 8'h21;
    localparam logic [7:0] RSP_NAK   = 8'h3F;
    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam logic [7:0] LAST_IDX  = 8'(DUMP_BYTES);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_ack;
    logic [7:0] r_ack_data;
    logic       r_pipe_reset;

    state_t     w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_ack_nxt;
    logic [7:0] w_ack_data_nxt;
    logic       w_pipe_reset_nxt;
    logic       w_read;
    logic       w_dumping;

    // State, frame counter and one-cycle response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'h00;
            r_ack        <= 1'b0;
            r_ack_data   <= 8'h00;
            r_pipe_reset <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ack        <= w_ack_nxt;
            r_ack_data   <= w_ack_data_nxt;
            r_pipe_reset <= w_pipe_reset_nxt;
        end
    end

    // Command decode and next-state selection
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = 8'h00;
        w_ack_nxt        = 1'b0;
        w_ack_data_nxt   = 8'h00;
        w_pipe_reset_nxt = 1'b0;
        w_read           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.dataAvailable) begin
                    w_read = 1'b1;
                    case (bus.receivedData)
                        CMD_CONT:  w_state_nxt = bus.halted ? S_DUMP : S_RUN;
                        CMD_STEP:  w_state_nxt = S_STEP;
                        CMD_DUMP:  w_state_nxt = S_DUMP;
                        CMD_RESET: begin
                            w_pipe_reset_nxt = 1'b1;
                            w_ack_nxt        = 1'b1;
                            w_ack_data_nxt   = RSP_ACK;
                        end
                        default: begin
                            w_ack_nxt      = 1'b1;
                            w_ack_data_nxt = RSP_NAK;
                        end
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // Bytes are always consumed while running; a halt overrides whatever was popped
                w_read = bus.dataAvailable;
                if (bus.halted) begin
                    w_state_nxt = S_DUMP;
                end else if (bus.dataAvailable) begin
                    case (bus.receivedData)
                        CMD_PAUSE: w_state_nxt = S_IDLE;
                        CMD_RESET: begin
                            w_state_nxt      = S_IDLE;
                            w_pipe_reset_nxt = 1'b1;
                            w_ack_nxt        = 1'b1;
                            w_ack_data_nxt   = RSP_ACK;
                        end
                        default:   w_state_nxt = S_RUN;
                    endcase
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_STEP: begin
                w_state_nxt = S_DUMP;
            end
            S_DUMP: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'h01;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Data bytes pass straight through: debug_data already lags debug_addr by one cycle
    assign w_dumping       = ~reset & (r_state == S_DUMP);
    assign bus.readFlag    = ~reset & w_read;
    assign bus.pipe_enable = ~reset & ~bus.halted & ((r_state == S_RUN) | (r_state == S_STEP));
    assign bus.writeFlag   = w_dumping | (~reset & r_ack);
    assign bus.dataToSend  = reset     ? 8'h00 :
                             w_dumping ? ((r_cnt == 8'h00) ? FRAME_HDR : bus.debug_data) :
                                         r_ack_data;
    assign bus.debug_addr  = w_dumping ? r_cnt : 8'h00;
    assign bus.pipe_reset  = ~reset & r_pipe_reset;
    assign bus.running     = ~reset & (r_state == S_RUN);
endmodule
